gf180mcu_fd_sc_mcu9t5v0__nchain_shift_tx: RTL and testbench

Rising-edge serial transmitter/unloader for chains of negative-edge D flops (dffnq-class cells).
- Accepts a parallel word and drives it bit-serially on SO, with a SHIFT_EN window.
- Each bit is launched on CLK rise, so the downstream falling-edge chain samples it mid-bit.
- Samples the returning chain output SI on each rising edge and presents the unloaded word on a valid/ready output port.
- Used as the test/characterisation driver for falling-edge register chains.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__nchain_shift_tx.sv | 137 +++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__nchain_shift_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nchain_shift_tx.sv
// Rising-edge serial driver/unloader for falling-edge flop chains: shifts a word out on SO
// under a SHIFT_EN window and captures the returning SI stream into a valid/ready word.
module gf180mcu_fd_sc_mcu9t5v0__nchain_shift_tx #(
  parameter int WIDTH      = 8,
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             SO,
  output logic             SHIFT_EN,
  input  logic             SI,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             BUSY
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             so_q, so_d;
  logic             shift_en_q, shift_en_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] shift_adv_s;
  logic [CW-1:0]    cap_idx_s;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  // The bit to transmit next always sits at the outgoing end of the shift register.
  assign shift_adv_s = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
  assign cap_idx_s   = LSB_FIRST ? cnt_q : (CNT_LAST - cnt_q);

  // Next-state and datapath decode.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cap_d       = cap_q;
    out_data_d  = out_data_q;
    cnt_d       = cnt_q;
    so_d        = so_q;
    shift_en_d  = shift_en_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          shift_d    = IN_DATA;
          so_d       = first_bit(IN_DATA);
          shift_en_d = 1'b1;
          cnt_d      = {CW{1'b0}};
          state_d    = ST_SHIFT;
        end else begin
          so_d       = IDLE_LEVEL;
          shift_en_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        // SI seen at this edge was launched one edge earlier and belongs to slot cnt_q.
        for (int i = 0; i < WIDTH; i++) begin
          cap_d[i] = (cap_idx_s == CW'(i)) ? SI : cap_q[i];
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          shift_en_d  = 1'b0;
          so_d        = IDLE_LEVEL;
          out_data_d  = cap_d;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          shift_d = shift_adv_s;
          so_d    = first_bit(shift_adv_s);
        end
      end
      ST_HOLD: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        so_d        = IDLE_LEVEL;
        shift_en_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q     <= ST_IDLE;
      shift_q     <= {WIDTH{1'b0}};
      cap_q       <= {WIDTH{1'b0}};
      out_data_q  <= {WIDTH{1'b0}};
      cnt_q       <= {CW{1'b0}};
      so_q        <= IDLE_LEVEL;
      shift_en_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cap_q       <= cap_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
      so_q        <= so_d;
      shift_en_q  <= shift_en_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign SO        = so_q;
  assign SHIFT_EN  = shift_en_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_VALID = out_valid_q;
  assign IN_READY  = (state_q == ST_IDLE);
  assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__nchain_shift_tx.sv
// Bench: LSB-first instance looped back through a falling-edge flop, MSB-first instance
// fed a constant SI; results compared against a word-level model of the transfer.
module tb_gf180mcu_fd_sc_mcu9t5v0__nchain_shift_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         total = 0;
  int         bad = 0;

  logic [7:0] a_in_data = 8'h00, b_in_data = 8'h00;
  logic       a_in_valid = 1'b0, b_in_valid = 1'b0;
  logic       a_out_ready = 1'b1, b_out_ready = 1'b1;
  logic       a_in_ready, b_in_ready, a_so, b_so, a_shift_en, b_shift_en;
  logic [7:0] a_out_data, b_out_data;
  logic       a_out_valid, b_out_valid, a_busy, b_busy;
  logic       a_chain = 1'b0;
  logic       b_si_const = 1'b0;

  always #5 clk = ~clk;

  // One-stage falling-edge chain between SO and SI of the LSB-first instance.
  always @(negedge clk) a_chain <= a_so;

  gf180mcu_fd_sc_mcu9t5v0__nchain_shift_tx #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
    .CLK(clk), .RN(rst_n), .IN_DATA(a_in_data), .IN_VALID(a_in_valid), .IN_READY(a_in_ready),
    .SO(a_so), .SHIFT_EN(a_shift_en), .SI(a_chain), .OUT_DATA(a_out_data),
    .OUT_VALID(a_out_valid), .OUT_READY(a_out_ready), .BUSY(a_busy));

  gf180mcu_fd_sc_mcu9t5v0__nchain_shift_tx #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b (
    .CLK(clk), .RN(rst_n), .IN_DATA(b_in_data), .IN_VALID(b_in_valid), .IN_READY(b_in_ready),
    .SO(b_so), .SHIFT_EN(b_shift_en), .SI(b_si_const), .OUT_DATA(b_out_data),
    .OUT_VALID(b_out_valid), .OUT_READY(b_out_ready), .BUSY(b_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transmission order as a word: bit c of the result is the c-th bit put on the wire.
  function automatic logic [7:0] wire_order(input bit msb, input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = msb ? w[7 - i] : w[i];
    return r;
  endfunction

  task automatic run_xfer(input bit use_b, input logic [7:0] w, output logic [7:0] seq,
                          output int en_cyc, output int lat, output logic [7:0] got);
    seq = 8'h00; en_cyc = 0; lat = -1; got = 8'h00;
    if (use_b) begin b_in_data = w; b_in_valid = 1'b1; end
    else begin a_in_data = w; a_in_valid = 1'b1; end
    tick();
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) seq[c] = use_b ? b_so : a_so;
      if (use_b ? b_shift_en : a_shift_en) en_cyc++;
      if (lat < 0 && (use_b ? b_out_valid : a_out_valid)) begin
        lat = c;
        got = use_b ? b_out_data : a_out_data;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 7; c++) begin
      if (c == 3) rst_n = 1'b1;
      @(negedge clk);
      total++;
      if ({a_so, a_shift_en, a_out_valid, a_in_ready, a_busy, a_out_data} !== {5'b00010, 8'h00}) begin
        bad++;
        $display("FAIL reset_a cyc=%0d: got so/en/ov/rdy/busy/data=%b want 00010_00000000", c,
                 {a_so, a_shift_en, a_out_valid, a_in_ready, a_busy, a_out_data});
      end
      total++;
      if ({b_so, b_shift_en, b_out_valid, b_in_ready, b_busy, b_out_data} !== {5'b00010, 8'h00}) begin
        bad++;
        $display("FAIL reset_b cyc=%0d: got so/en/ov/rdy/busy/data=%b want 00010_00000000", c,
                 {b_so, b_shift_en, b_out_valid, b_in_ready, b_busy, b_out_data});
      end
    end
    tick();
  endtask

  task automatic check_xfer(input string name, input bit use_b, input logic [7:0] w,
                            input logic [7:0] exp_out);
    logic [7:0] seq, got;
    int en_cyc, lat;
    run_xfer(use_b, w, seq, en_cyc, lat, got);
    total++;
    if (seq !== wire_order(use_b, w)) begin
      bad++; $display("FAIL %s_so word=%h: got seq %b want %b", name, w, seq, wire_order(use_b, w));
    end
    total++;
    if (en_cyc != 8) begin
      bad++; $display("FAIL %s_shift_en word=%h: got %0d cycles want 8", name, w, en_cyc);
    end
    total++;
    if (lat != 8) begin
      bad++; $display("FAIL %s_latency word=%h: got %0d want 8", name, w, lat);
    end
    total++;
    if (got !== exp_out) begin
      bad++; $display("FAIL %s_out word=%h: got %h want %h", name, w, got, exp_out);
    end
  endtask

  task automatic test_lsb_loopback();
    check_xfer("lsb_loop", 1'b0, 8'hA5, 8'hA5);
    for (int n = 0; n < 4; n++) begin
      logic [7:0] w;
      w = 8'($urandom);
      check_xfer("lsb_loop_rnd", 1'b0, w, w);
    end
  endtask

  task automatic test_msb_const();
    b_si_const = 1'b1;
    check_xfer("msb_si1", 1'b1, 8'h81, 8'hFF);
    b_si_const = 1'b0;
    check_xfer("msb_si0", 1'b1, 8'h81, 8'h00);
    for (int n = 0; n < 4; n++) begin
      logic [7:0] w;
      w = 8'($urandom);
      b_si_const = 1'($urandom);
      check_xfer("msb_rnd", 1'b1, w, {8{b_si_const}});
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] w;
    bit seen;
    w = 8'hC3;
    a_out_ready = 1'b0;
    a_in_data = w; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    for (int c = 0; c < 20 && !a_out_valid; c++) tick();
    total++;
    if (a_out_valid !== 1'b1 || a_out_data !== w) begin
      bad++; $display("FAIL bp_first: got valid=%b data=%h want 1 %h", a_out_valid, a_out_data, w);
    end
    a_in_data = 8'h3C; a_in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if ({a_in_ready, a_busy, a_out_valid, a_shift_en, a_out_data} !== {4'b0110, w}) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d: got rdy/busy/ov/en/data=%b want 0110_%b", c,
                 {a_in_ready, a_busy, a_out_valid, a_shift_en, a_out_data}, w);
      end
    end
    a_out_ready = 1'b1;
    tick();
    total++;
    if ({a_in_ready, a_out_valid, a_shift_en} !== 3'b100) begin
      bad++; $display("FAIL bp_release: got rdy/ov/en=%b want 100", {a_in_ready, a_out_valid, a_shift_en});
    end
    tick();
    a_in_valid = 1'b0;
    total++;
    if ({a_shift_en, a_busy, a_so} !== 3'b110) begin
      bad++; $display("FAIL bp_accept: got en/busy/so=%b want 110", {a_shift_en, a_busy, a_so});
    end
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      seen = a_out_valid;
    end
    total++;
    if (!seen || a_out_data !== 8'h3C) begin
      bad++; $display("FAIL bp_second: got seen=%b data=%h want 1 3c", seen, a_out_data);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    a_in_data = 8'($urandom); a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    repeat (3) tick();
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({a_so, a_shift_en, a_busy, a_in_ready, a_out_valid, a_out_data} !== {5'b00010, 8'h00}) begin
      bad++;
      $display("FAIL mid_reset: got so/en/busy/rdy/ov/data=%b want 00010_00000000",
               {a_so, a_shift_en, a_busy, a_in_ready, a_out_valid, a_out_data});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_xfer("after_reset", 1'b0, 8'h5A, 8'h5A);
  endtask

  task automatic test_back_to_back();
    logic [7:0] sent[$];
    logic [7:0] exp, d;
    int last_acc, n_rx;
    bit acc;
    last_acc = -1; n_rx = 0;
    a_out_ready = 1'b1;
    a_in_data = 8'($urandom); a_in_valid = 1'b1;
    for (int cyc = 0; cyc < 100 && n_rx < 5; cyc++) begin
      acc = a_in_ready && a_in_valid;
      d = a_in_data;
      tick();
      if (acc) begin
        sent.push_back(d);
        if (last_acc >= 0) begin
          total++;
          if (cyc - last_acc != 10) begin
            bad++; $display("FAIL b2b_spacing: got %0d cycles want 10", cyc - last_acc);
          end
        end
        last_acc = cyc;
        a_in_data = 8'($urandom);
      end
      if (a_out_valid) begin
        total++;
        if (sent.size() == 0) begin
          bad++; $display("FAIL b2b_unexpected: got word %h want none", a_out_data);
        end else begin
          exp = sent.pop_front();
          n_rx++;
          if (a_out_data !== exp) begin
            bad++; $display("FAIL b2b_data: got %h want %h", a_out_data, exp);
          end
        end
      end
    end
    total++;
    if (n_rx != 5) begin
      bad++; $display("FAIL b2b_timeout: got %0d words want 5", n_rx);
    end
    a_in_valid = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    test_reset();
    test_lsb_loopback();
    test_msb_const();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1);
  end

endmodule
